// File: rtl/ram_port_ctrl.sv
// Command front-end for a 1W/1R synchronous RAM: registered port drive, 2-cycle read response via FIFO.
// cmd_ready reserves a FIFO slot per in-flight read, so read data is never dropped under rsp back-pressure.
module ram_port_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic                  p1;
    logic                  p2;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [SW-1:0]         credit_used;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  full;

    // Slots already promised: stored entries plus reads still travelling through the RAM.
    assign credit_used = {1'b0, fifo_count} + SW'(p1) + SW'(p2);
    assign cmd_ready   = credit_used < SW'(RSP_DEPTH);
    assign accept      = cmd_valid && cmd_ready;

    assign push      = p2;
    assign rsp_valid = fifo_count != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];
    assign full      = fifo_count == CW'(RSP_DEPTH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            p1          <= 1'b0;
            p2          <= 1'b0;
            wr_count    <= '0;
            rd_count    <= '0;
        end else begin
            ram_wr_en <= accept && cmd_write;
            ram_rd_en <= accept && !cmd_write;
            p1        <= accept && !cmd_write;
            p2        <= p1;
            if (accept && cmd_write) begin
                ram_wr_addr <= cmd_addr;
                ram_wr_data <= cmd_wdata;
                wr_count    <= wr_count + 16'd1;
            end
            if (accept && !cmd_write) begin
                ram_rd_addr <= cmd_addr;
                rd_count    <= rd_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ram_rd_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rstn) !(push && full));

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl: directed steps plus a random phase, checked against a queue-based model.
module tb_ram_port_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NWORD = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [15:0]   wr_count;
    logic [15:0]   rd_count;

    ram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    // The RAM itself: registered read, cleared by the shared reset.
    logic [DW-1:0] ram [NWORD];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NWORD; i++) ram[i] <= '0;
            ram_rd_data <= '0;
        end else begin
            if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
            if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
        end
    end

    // Model: each accepted read is a queue entry stamped with its acceptance edge.
    typedef struct {
        logic [DW-1:0] data;
        int            t;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] ref_mem [NWORD];
    int            cyc;
    logic [15:0]   m_wr;
    logic [15:0]   m_rd;
    logic          e_wr_en;
    logic [AW-1:0] e_wr_addr;
    logic [DW-1:0] e_wr_data;
    logic          e_rd_en;
    logic [AW-1:0] e_rd_addr;
    int            checks;
    int            failures;
    int            n_pop;
    logic          acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < NWORD; i++) ref_mem[i] = '0;
        m_wr = '0; m_rd = '0;
        e_wr_en = 1'b0; e_wr_addr = '0; e_wr_data = '0;
        e_rd_en = 1'b0; e_rd_addr = '0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic er, ev;
        ent_t e;
        @(negedge clk);
        er = q.size() < DEPTH;
        ev = (q.size() > 0) && (q[0].t + 2 <= cyc);
        chk("cmd_ready", 32'(cmd_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(e_wr_en));
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(e_wr_addr));
        chk("ram_wr_data", 32'(ram_wr_data), 32'(e_wr_data));
        chk("ram_rd_en", 32'(ram_rd_en), 32'(e_rd_en));
        chk("ram_rd_addr", 32'(ram_rd_addr), 32'(e_rd_addr));
        chk("wr_count", 32'(wr_count), 32'(m_wr));
        chk("rd_count", 32'(rd_count), 32'(m_rd));
        acc = cmd_valid && er;
        @(posedge clk);
        cyc++;
        if (ev && rsp_ready) begin
            void'(q.pop_front());
            n_pop++;
        end
        e_wr_en = acc && cmd_write;
        e_rd_en = acc && !cmd_write;
        if (acc && cmd_write) begin
            ref_mem[cmd_addr] = cmd_wdata;
            e_wr_addr = cmd_addr;
            e_wr_data = cmd_wdata;
            m_wr = m_wr + 16'd1;
        end
        if (acc && !cmd_write) begin
            e.data = ref_mem[cmd_addr];
            e.t    = cyc;
            q.push_back(e);
            e_rd_addr = cmd_addr;
            m_rd = m_rd + 16'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_clear();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_ram_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_ram_addr", 32'({ram_wr_addr, ram_rd_addr}), 32'd0);
        chk("rst_ram_wr_data", 32'(ram_wr_data), 32'd0);
        chk("rst_counts", {wr_count, rd_count}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) tick();
        chk("send_accept", 32'(acc), 32'd1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int base, n, gaps, ticks;
        checks = 0; failures = 0; n_pop = 0; cyc = 0;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        model_clear();
        #12;
        do_reset();
        repeat (3) tick();

        // Write then read addr 3; data is visible two edges after the read is accepted.
        send(1'b1, 4'd3, 8'hA5);
        send(1'b0, 4'd3, 8'h00);
        tick();
        chk("lat_valid_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(rsp_valid), 32'd1);
        chk("lat_data", 32'(rsp_data), 32'hA5);
        chk("lat_wr_count", 32'(wr_count), 32'd1);
        chk("lat_rd_count", 32'(rd_count), 32'd1);
        rsp_ready = 1'b1;
        repeat (3) tick();

        // Back-to-back reads of all addresses with rsp_ready high.
        for (int i = 0; i < NWORD; i++) send(1'b1, AW'(i), DW'(i) ^ 8'h5A);
        base = n_pop; n = 0; ticks = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0;
        while (n < NWORD && ticks < 60) begin
            tick();
            ticks++;
            if (acc) begin
                n++;
                cmd_addr = AW'(n);
            end
        end
        cmd_valid = 1'b0;
        gaps = ticks - n;
        chk("b2b_accepts", 32'(n), 32'(NWORD));
        chk("b2b_gaps", 32'(gaps), 32'd0);
        repeat (4) tick();
        chk("b2b_responses", 32'(n_pop - base), 32'(NWORD));

        // Six reads under back-pressure: credits stop acceptance at the FIFO depth.
        rsp_ready = 1'b0; n = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0;
        repeat (8) begin
            tick();
            if (acc) begin
                n++;
                cmd_addr = AW'(n);
            end
        end
        chk("stall_accepts", 32'(n), 32'd4);
        chk("stall_held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1; base = n_pop;
        for (int k = 0; k < 30 && n < 6; k++) begin
            tick();
            if (acc) begin
                n++;
                cmd_addr = AW'(n);
            end
        end
        cmd_valid = 1'b0;
        chk("stall_rest", 32'(n), 32'd6);
        repeat (6) tick();
        chk("stall_drain", 32'(n_pop - base), 32'd6);

        // Reset with two reads in flight: nothing comes back afterwards.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd1;
        tick();
        cmd_addr = 4'd2;
        tick();
        cmd_valid = 1'b0;
        do_reset();
        rsp_ready = 1'b1; base = n_pop;
        repeat (5) tick();
        chk("rst_no_rsp", 32'(n_pop - base), 32'd0);

        // Write immediately followed by a read of the same address.
        send(1'b1, 4'd7, 8'h3C);
        send(1'b0, 4'd7, 8'h00);
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("raw_data", 32'(rsp_data), 32'h3C);
        rsp_ready = 1'b1;
        repeat (3) tick();

        // Counter wrap: 65535 streamed writes, then one more.
        do_reset();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd15; cmd_wdata = 8'h77;
        repeat (65535) @(posedge clk);
        #1;
        m_wr = 16'hFFFF; ref_mem[15] = 8'h77;
        e_wr_en = 1'b1; e_wr_addr = 4'd15; e_wr_data = 8'h77;
        chk("wrap_pre", 32'(wr_count), 32'hFFFF);
        tick();
        cmd_valid = 1'b0;
        chk("wrap_post", 32'(wr_count), 32'd0);
        tick();

        // Random traffic; payload is held while a command waits for ready.
        for (int k = 0; k < 500; k++) begin
            if (!(cmd_valid && !acc)) begin
                cmd_valid = ($urandom_range(0, 3) != 0);
                cmd_write = $urandom_range(0, 1) == 1;
                cmd_addr  = AW'($urandom_range(0, NWORD - 1));
                cmd_wdata = DW'($urandom);
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (8) tick();
        chk("final_empty", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
